// File: rtl/fetch_redirect_unit.sv
// Instruction-fetch sequencer: owns the PC and IF/ID register, applies decode redirects and stalls.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_redirect_unit #(
  parameter int unsigned         PC_WIDTH  = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter logic [31:0]         NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_id,
  input  logic                branch,
  input  logic                branch_taken,
  input  logic                jump,
  input  logic                IF_flush,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic [31:0]         imem_instr,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] if_id_pc,
  output logic [31:0]         if_id_instr,
  output logic                if_id_valid,
  output logic                redirect_err,
  output logic                misaligned
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_flush_cnt,
  output logic [31:0]         perf_stall_cnt
`endif
);

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = 32;

  localparam logic [1:0] S_INIT   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_BUBBLE = 2'd2;
  localparam logic [1:0] S_STALL  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] if_id_pc_q, if_id_pc_d;
  logic [INSTR_W-1:0]  if_id_instr_q, if_id_instr_d;
  logic                if_id_valid_q, if_id_valid_d;
  logic                redirect_err_q, redirect_err_d;
  logic                misaligned_q, misaligned_d;

  logic                fetch_ev_c;
  logic                flush_ev_c;
  logic                stall_ev_c;
  logic [PC_WIDTH-1:0] sel_target_c;
  logic                legal_redirect_c;

  // Jump wins target selection; an unjustified flush still falls back to branch_target.
  assign sel_target_c     = jump ? jump_target : branch_target;
  assign legal_redirect_c = jump | (branch & branch_taken);

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_INIT;
      pc_q           <= RESET_PC;
      if_id_pc_q     <= '0;
      if_id_instr_q  <= NOP_INSTR;
      if_id_valid_q  <= 1'b0;
      redirect_err_q <= 1'b0;
      misaligned_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      if_id_pc_q     <= if_id_pc_d;
      if_id_instr_q  <= if_id_instr_d;
      if_id_valid_q  <= if_id_valid_d;
      redirect_err_q <= redirect_err_d;
      misaligned_q   <= misaligned_d;
    end
  end

  // Next-state: stall beats flush beats sequential advance
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    if_id_pc_d     = if_id_pc_q;
    if_id_instr_d  = if_id_instr_q;
    if_id_valid_d  = if_id_valid_q;
    redirect_err_d = 1'b0;
    misaligned_d   = 1'b0;
    fetch_ev_c     = 1'b0;
    flush_ev_c     = 1'b0;
    stall_ev_c     = 1'b0;

    case (state_q)
      S_INIT: begin
        state_d = S_RUN;
      end
      default: begin
        if (stall_id) begin
          // A stalled decode decision is not final; decode re-presents it later.
          state_d    = S_STALL;
          stall_ev_c = 1'b1;
        end else if (IF_flush) begin
          state_d        = S_BUBBLE;
          pc_d           = {sel_target_c[PC_WIDTH-1:2], 2'b00};
          if_id_pc_d     = pc_q;
          if_id_instr_d  = NOP_INSTR;
          if_id_valid_d  = 1'b0;
          misaligned_d   = |sel_target_c[1:0];
          redirect_err_d = ~legal_redirect_c;
          flush_ev_c     = 1'b1;
        end else begin
          state_d       = S_RUN;
          pc_d          = pc_q + PC_WIDTH'(4);
          if_id_pc_d    = pc_q;
          if_id_instr_d = imem_instr;
          if_id_valid_d = 1'b1;
          fetch_ev_c    = 1'b1;
        end
      end
    endcase
  end

  assign pc           = pc_q;
  assign if_id_pc     = if_id_pc_q;
  assign if_id_instr  = if_id_instr_q;
  assign if_id_valid  = if_id_valid_q;
  assign redirect_err = redirect_err_q;
  assign misaligned   = misaligned_q;

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] fetch_cnt_q, flush_cnt_q, stall_cnt_q;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (fetch_ev_c && (fetch_cnt_q != '1)) fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
      if (flush_ev_c && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      if (stall_ev_c && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  logic unused_ev_c;
  assign unused_ev_c = fetch_ev_c ^ flush_ev_c ^ stall_ev_c ^ (CNT_W == 0);
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit: reset, free-run, redirects, stalls, errors and PC wrap.
module tb_fetch_redirect_unit;

  localparam int unsigned PC_W = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall_id;
  logic            branch;
  logic            branch_taken;
  logic            jump;
  logic            IF_flush;
  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] jump_target;
  logic [31:0]     imem_instr;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] if_id_pc;
  logic [31:0]     if_id_instr;
  logic            if_id_valid;
  logic            redirect_err;
  logic            misaligned;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]     perf_fetch_cnt;
  logic [31:0]     perf_flush_cnt;
  logic [31:0]     perf_stall_cnt;
`endif

  int vectors = 0;
  int errs    = 0;

  fetch_redirect_unit #(
    .PC_WIDTH (PC_W),
    .RESET_PC ('0),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_id     (stall_id),
    .branch       (branch),
    .branch_taken (branch_taken),
    .jump         (jump),
    .IF_flush     (IF_flush),
    .branch_target(branch_target),
    .jump_target  (jump_target),
    .imem_instr   (imem_instr),
    .pc           (pc),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid),
    .redirect_err (redirect_err),
    .misaligned   (misaligned)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_flush_cnt(perf_flush_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Combinational instruction memory: word n holds 0x11*(n+1)
  assign imem_instr = (32'(pc[31:2]) + 32'd1) * 32'h11;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_ctl();
    stall_id = 1'b0; branch = 1'b0; branch_taken = 1'b0; jump = 1'b0; IF_flush = 1'b0;
  endtask

  task automatic chk_ifid(input string tag, input logic [63:0] epc, input logic [63:0] eipc,
                          input logic [31:0] einstr, input logic evalid);
    check({tag, ".pc"}, pc, epc);
    check({tag, ".if_id_pc"}, if_id_pc, eipc);
    check({tag, ".if_id_instr"}, 64'(if_id_instr), 64'(einstr));
    check({tag, ".if_id_valid"}, 64'(if_id_valid), 64'(evalid));
  endtask

  initial begin
    rst = 1'b1; clear_ctl();
    branch_target = '0; jump_target = '0;
    step(); step();
    chk_ifid("reset", 64'h0, 64'h0, 32'h13, 1'b0);
    check("reset.err", 64'(redirect_err), 64'h0);
    check("reset.mis", 64'(misaligned), 64'h0);

    // Free run out of reset: INIT cycle, then sequential fetch
    rst = 1'b0;
    step(); chk_ifid("init", 64'h0, 64'h0, 32'h13, 1'b0);
    step(); chk_ifid("run1", 64'h4, 64'h0, 32'h11, 1'b1);
    step(); chk_ifid("run2", 64'h8, 64'h4, 32'h22, 1'b1);
    step(); chk_ifid("run3", 64'hC, 64'h8, 32'h33, 1'b1);
    step(); chk_ifid("run4", 64'h10, 64'hC, 32'h44, 1'b1);

    // Jump redirect from pc=0x10
    jump = 1'b1; IF_flush = 1'b1; jump_target = 64'h100;
    step(); chk_ifid("jal", 64'h100, 64'h10, 32'h13, 1'b0);
    check("jal.err", 64'(redirect_err), 64'h0);
    clear_ctl();
    step(); chk_ifid("jal+1", 64'h104, 64'h100, 32'h451, 1'b1);

    // Taken branch held under a two-cycle stall
    stall_id = 1'b1; branch = 1'b1; branch_taken = 1'b1; IF_flush = 1'b1; branch_target = 64'h40;
    step(); chk_ifid("stall1", 64'h104, 64'h100, 32'h451, 1'b1);
    step(); chk_ifid("stall2", 64'h104, 64'h100, 32'h451, 1'b1);
    stall_id = 1'b0;
    step(); chk_ifid("br", 64'h40, 64'h104, 32'h13, 1'b0);
    clear_ctl();
    step(); chk_ifid("br+1", 64'h44, 64'h40, 32'h121, 1'b1);

    // Back-to-back flushes, second one taken from BUBBLE
    branch = 1'b1; branch_taken = 1'b1; IF_flush = 1'b1; branch_target = 64'h80;
    step(); chk_ifid("b2b1", 64'h80, 64'h44, 32'h13, 1'b0);
    branch_target = 64'hC0;
    step(); chk_ifid("b2b2", 64'hC0, 64'h80, 32'h13, 1'b0);
    clear_ctl();
    step(); chk_ifid("b2b+1", 64'hC4, 64'hC0, 32'h341, 1'b1);

    // Unjustified flush with misaligned branch target
    IF_flush = 1'b1; branch_target = 64'h203;
    step(); chk_ifid("err", 64'h200, 64'hC4, 32'h13, 1'b0);
    check("err.err", 64'(redirect_err), 64'h1);
    check("err.mis", 64'(misaligned), 64'h1);
    clear_ctl();
    step(); chk_ifid("err+1", 64'h204, 64'h200, 32'h891, 1'b1);
    check("err+1.err", 64'(redirect_err), 64'h0);
    check("err+1.mis", 64'(misaligned), 64'h0);

    // Not-taken branch: plain advance
    branch = 1'b1; branch_taken = 1'b0;
    step(); chk_ifid("ntaken", 64'h208, 64'h204, 32'h8A2, 1'b1);
    clear_ctl();

    // Legal jump with misaligned target
    jump = 1'b1; IF_flush = 1'b1; jump_target = 64'h102;
    step(); check("jmis.pc", pc, 64'h100);
    check("jmis.mis", 64'(misaligned), 64'h1);
    check("jmis.err", 64'(redirect_err), 64'h0);

    // Redirect to top of address space, then wrap
    jump_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step(); chk_ifid("top", 64'hFFFF_FFFF_FFFF_FFFC, 64'h100, 32'h13, 1'b0);
    check("top.mis", 64'(misaligned), 64'h0);
    clear_ctl();
    step(); chk_ifid("wrap", 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h4000_0000, 1'b1);
    step(); chk_ifid("wrap+1", 64'h4, 64'h0, 32'h11, 1'b1);

`ifdef FETCH_PERF_CNT_EN
    check("perf.fetch", 64'(perf_fetch_cnt), 64'd11);
    check("perf.flush", 64'(perf_flush_cnt), 64'd7);
    check("perf.stall", 64'(perf_stall_cnt), 64'd2);
`endif

    // Reset mid-operation discards pending stall and redirect
    rst = 1'b1; stall_id = 1'b1; IF_flush = 1'b1; jump = 1'b1; jump_target = 64'h300;
    step(); chk_ifid("rst2", 64'h0, 64'h0, 32'h13, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    check("rst2.fetch", 64'(perf_fetch_cnt), 64'd0);
`endif
    rst = 1'b0; clear_ctl();
    step(); chk_ifid("rst2.init", 64'h0, 64'h0, 32'h13, 1'b0);
    step(); chk_ifid("rst2.run", 64'h4, 64'h0, 32'h11, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_unit.md
# fetch_redirect_unit

Instruction-fetch sequencer at the front end of the 5-stage RISC-V pipeline. Owns the program counter and the IF/ID pipeline register. Consumes the decode-stage redirect signals (`branch`, `branch_taken`, `jump`, `IF_flush`) and the hazard stall. Steers the PC, squashes wrong-path fetches and inserts bubbles, so every redirect requested at decode is honoured exactly once.

## Interface
Parameters:
- `PC_WIDTH`, 64, width of PC and targets
- `RESET_PC`, 0, first fetch address after reset
- `NOP_INSTR`, 32'h00000013, instruction placed in IF/ID on a bubble (`addi x0,x0,0`)

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `stall_id`  in  1  hazard unit holds ID (load-use); freeze PC and IF/ID
- `branch`  in  1  decode: instruction in ID is a conditional branch
- `branch_taken`  in  1  decode: branch condition resolved true
- `jump`  in  1  decode: instruction in ID is `jal`
- `IF_flush`  in  1  decode: redirect fetch, squash IF
- `branch_target`  in  PC_WIDTH  target for taken branch
- `jump_target`  in  PC_WIDTH  target for jump
- `imem_instr`  in  32  instruction memory read data for `pc`, same cycle (combinational memory)
- `pc`  out  PC_WIDTH  current fetch address
- `if_id_pc`  out  PC_WIDTH  PC of instruction in IF/ID
- `if_id_instr`  out  32  instruction in IF/ID
- `if_id_valid`  out  1  IF/ID holds a real instruction
- `redirect_err`  out  1  one-cycle pulse: `IF_flush` without `jump` or `branch&branch_taken`
- `misaligned`  out  1  one-cycle pulse: selected target had bits [1:0] ≠ 0

## Operation
- States: INIT, RUN, BUBBLE, STALL.
- Reset (`rst`=1): state INIT. `pc`=RESET_PC. `if_id_pc`=0. `if_id_instr`=NOP_INSTR. `if_id_valid`=0. `redirect_err`=0. `misaligned`=0. Reset mid-operation discards any pending redirect or stall.
- INIT: one cycle. IF/ID stays a bubble, `pc` holds RESET_PC. Then go to RUN.
- Per-cycle priority, evaluated in RUN/BUBBLE/STALL: `stall_id` > `IF_flush` > normal advance.
- `stall_id`=1: `pc` and IF/ID hold. State STALL. `IF_flush` is ignored, because the decision of a stalled instruction is not final. Decode re-presents it after the stall releases.
- `IF_flush`=1 (no stall):
  - target = `jump` ? `jump_target` : `branch_target`, with bits [1:0] forced to 0.
  - `pc` ← target.
  - IF/ID ← {`pc`, NOP_INSTR, valid 0}. The wrong-path fetch is squashed.
  - State BUBBLE.
  - `misaligned` pulses if original target bits [1:0] ≠ 0.
  - `redirect_err` pulses if neither `jump` nor (`branch`&`branch_taken`) is set; the redirect still uses `branch_target`.
- Normal advance: `pc` ← `pc`+4, modulo 2^PC_WIDTH (wraps silently). IF/ID ← {`pc`, `imem_instr`, valid 1}. State RUN.
- BUBBLE lasts exactly one cycle unless re-flushed or stalled. A flush in BUBBLE is legal and redirects again. This cannot originate from a squashed instruction, since IF/ID was invalid.
- `branch`=1 with `branch_taken`=0 and `IF_flush`=0: normal advance, no penalty.

## Timing
- `pc` is registered; `imem_instr` is valid in the same cycle.
- Redirect latency, `IF_flush` sampled at edge N:
  - after edge N: `pc`=target, `if_id_valid`=0.
  - after edge N+1: `if_id_instr`=mem[target], `if_id_valid`=1.
  - Penalty: 1 bubble.
- Stall: outputs are frozen for every cycle `stall_id`=1. They advance on the first edge with `stall_id`=0.
- `redirect_err` and `misaligned` are registered and high for exactly one cycle after the offending edge.
- After `rst` deasserts at edge R: the first valid IF/ID (instr at RESET_PC) appears after edge R+2.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - adds outputs `perf_fetch_cnt` [31:0] (valid instructions loaded into IF/ID), `perf_flush_cnt` [31:0] (accepted redirects) and `perf_stall_cnt` [31:0] (stall cycles).
  - All three counters reset to 0 and saturate at 32'hFFFFFFFF.
- Not defined: the ports and the counter logic are absent, and behaviour is otherwise identical.

## Test plan
- Reset then 4 free-run cycles, RESET_PC=0, imem returns 0x11,0x22,… → after edge R+2: `if_id_pc`=0, `if_id_instr`=0x11, valid 1; `pc` sequence 0,4,8,12.
- `jump`=1, `IF_flush`=1, `jump_target`=0x100 at `pc`=0x10 → next cycle `pc`=0x100, `if_id_valid`=0, `if_id_instr`=0x00000013; following cycle `if_id_pc`=0x100, valid 1.
- Taken branch, `branch_target`=0x40, with `stall_id`=1 for 2 cycles and flush held throughout → `pc` and IF/ID frozen 2 cycles, no redirect; redirect to 0x40 on the first unstalled edge.
- Back-to-back flushes to 0x80 then 0xC0 on consecutive cycles → `pc`=0x80 then 0xC0, `if_id_valid`=0 for 2 cycles, then `if_id_pc`=0xC0 valid.
- `IF_flush`=1 with `jump`=0, `branch`=0, `branch_target`=0x203 → `pc`=0x200, `redirect_err`=1 and `misaligned`=1 for one cycle each.
- `pc`=2^PC_WIDTH−4, free-run → `pc` wraps to 0. With FETCH_PERF_CNT_EN defined: counters match the counted fetch, flush and stall events across the whole test.
